llbit_ctrl: RTL and testbench

Controller for the LLbit resource in the MIPS pipeline.
- Tracks in-flight LL writes of LLbit between issue (EX) and writeback (WB) with an occupancy counter.
- Holds the architectural link state and link address.
- Arbitrates LLbit clear sources: WB write, snooped store, successful SC and exception/ERET flush.
- Decides SC success, and stalls SC issue while an older LL write is still outstanding.

---
 rtl/llbit_ctrl.sv | 119 +++++++++++
 tb/tb_llbit_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/llbit_ctrl.sv
// llbit_ctrl: LLbit resource controller for the MIPS pipeline.
//
// Tracks LL operations between EX issue and WB retirement, holds the
// architectural link state and link address, arbitrates the LLbit clear
// sources and decides SC success.
//
// state  | meaning
// IDLE   | no valid link; SC will fail
// LINKED | LLbit set; link_addr_q holds the linked word address
//
// Ports:
//   clk, rst_n       core clock (rising edge), async active-low reset
//   ll_issue         LL issued in EX, allocates one pending LLbit write
//   sc_issue/sc_addr SC in EX requesting LLbit evaluation
//   llbit_wr_wb, llbit_wdata_wb, link_addr_wb   LLbit write retiring at WB
//   store_valid/store_addr                      committed store snoop
//   excp_flush       exception/ERET flush
//   stall_req        hold EX: SC waiting on a pending LLbit write
//   pend_full        pending counter at PEND_DEPTH
//   sc_success       SC result, valid when sc_issue & ~stall_req
//   llbit            architectural LLbit
module llbit_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int PEND_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ll_issue,
  input  logic              sc_issue,
  input  logic [ADDR_W-1:0] sc_addr,
  input  logic              llbit_wr_wb,
  input  logic              llbit_wdata_wb,
  input  logic [ADDR_W-1:0] link_addr_wb,
  input  logic              store_valid,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic              excp_flush,
  output logic              stall_req,
  output logic              pend_full,
  output logic              sc_success,
  output logic              llbit
);

  typedef enum logic {IDLE = 1'b0, LINKED = 1'b1} state_e;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PEND_DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;
  logic [ADDR_W-1:0] link_addr_q, link_addr_d;

  logic linked;
  logic inc, dec;
  logic wb_set, wb_clr;
  logic store_hit, store_hit_new;
  logic clr_any;

  // Word-granular address compare: byte offset bits are ignored.
  function automatic logic addr_match(input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:2] == b[ADDR_W-1:2];
  endfunction

  assign linked    = (state_q == LINKED);
  assign llbit     = linked;
  assign pend_full = (pend_cnt_q == DEPTH_C);

  // An SC must not evaluate while an older LL write is still in flight,
  // otherwise it would read a stale LLbit. A flush kills the SC instead.
  assign stall_req  = sc_issue & (pend_cnt_q != '0) & ~excp_flush;
  assign sc_success = sc_issue & ~stall_req & ~excp_flush & linked
                    & addr_match(sc_addr, link_addr_q);

  assign inc = ll_issue & ~pend_full;
  assign dec = llbit_wr_wb & (pend_cnt_q != '0);

  assign wb_set = llbit_wr_wb & llbit_wdata_wb;
  assign wb_clr = llbit_wr_wb & ~llbit_wdata_wb;

  assign store_hit     = store_valid & linked & addr_match(store_addr, link_addr_q);
  // A store to the address being linked this very cycle must also break it.
  assign store_hit_new = store_valid & wb_set & addr_match(store_addr, link_addr_wb);

  assign clr_any = store_hit | store_hit_new | sc_success | wb_clr;

  always_comb begin
    state_d     = state_q;
    pend_cnt_d  = pend_cnt_q;
    link_addr_d = link_addr_q;

    if (excp_flush) begin
      state_d    = IDLE;
      pend_cnt_d = '0;
    end else begin
      if (inc && !dec)      pend_cnt_d = pend_cnt_q + CNT_W'(1);
      else if (dec && !inc) pend_cnt_d = pend_cnt_q - CNT_W'(1);

      if (clr_any) begin
        state_d = IDLE;
      end else if (wb_set) begin
        state_d     = LINKED;
        link_addr_d = link_addr_wb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_cnt_q  <= '0;
      link_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_cnt_q  <= pend_cnt_d;
      link_addr_q <= link_addr_d;
    end
  end

endmodule

// File: tb/tb_llbit_ctrl.sv
// Directed testbench for llbit_ctrl.
module tb_llbit_ctrl;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ll_issue, sc_issue, llbit_wr_wb, llbit_wdata_wb;
  logic              store_valid, excp_flush;
  logic [ADDR_W-1:0] sc_addr, link_addr_wb, store_addr;
  logic              stall_req, pend_full, sc_success, llbit;

  int n_tests = 0;
  int n_fail  = 0;

  llbit_ctrl #(.ADDR_W(ADDR_W), .PEND_DEPTH(4), .CNT_W(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ll_issue       (ll_issue),
    .sc_issue       (sc_issue),
    .sc_addr        (sc_addr),
    .llbit_wr_wb    (llbit_wr_wb),
    .llbit_wdata_wb (llbit_wdata_wb),
    .link_addr_wb   (link_addr_wb),
    .store_valid    (store_valid),
    .store_addr     (store_addr),
    .excp_flush     (excp_flush),
    .stall_req      (stall_req),
    .pend_full      (pend_full),
    .sc_success     (sc_success),
    .llbit          (llbit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    ll_issue = 0; sc_issue = 0; llbit_wr_wb = 0; llbit_wdata_wb = 0;
    store_valid = 0; excp_flush = 0;
    sc_addr = '0; link_addr_wb = '0; store_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_set(input logic [ADDR_W-1:0] a);
    llbit_wr_wb = 1; llbit_wdata_wb = 1; link_addr_wb = a;
  endtask

  initial begin
    clr_in();
    rst_n = 0;
    #12;
    check("rst_llbit", llbit, 0);
    check("rst_full", pend_full, 0);
    check("rst_stall", stall_req, 0);
    check("rst_sc", sc_success, 0);
    rst_n = 1;
    tick();

    // Basic link
    ll_issue = 1; tick(); clr_in();
    check("basic_cnt1", dut.pend_cnt_q, 1);
    tick();
    wb_set(32'h1000); #1;
    check("basic_llbit_pre", llbit, 0);
    tick(); clr_in();
    check("basic_cnt0", dut.pend_cnt_q, 0);
    check("basic_llbit1", llbit, 1);
    sc_issue = 1; sc_addr = 32'h1000; #1;
    check("basic_sc", sc_success, 1);
    check("basic_stall", stall_req, 0);
    tick(); clr_in();
    check("basic_llbit_after_sc", llbit, 0);

    // SC hazard
    ll_issue = 1; tick(); clr_in();
    sc_issue = 1; sc_addr = 32'h1000; #1;
    check("haz_stall_c1", stall_req, 1);
    check("haz_sc_c1", sc_success, 0);
    tick();
    wb_set(32'h1000); #1;
    check("haz_stall_c2", stall_req, 1);
    tick();
    llbit_wr_wb = 0; llbit_wdata_wb = 0; #1;
    check("haz_stall_c3", stall_req, 0);
    check("haz_sc_c3", sc_success, 1);
    tick(); clr_in();
    check("haz_llbit", llbit, 0);

    // Snoop clear
    wb_set(32'h2000); tick(); clr_in();
    check("snp_linked", llbit, 1);
    store_valid = 1; store_addr = 32'h2003; tick(); clr_in();
    check("snp_hit", llbit, 0);
    wb_set(32'h2000); tick(); clr_in();
    store_valid = 1; store_addr = 32'h2004; tick(); clr_in();
    check("snp_miss", llbit, 1);
    llbit_wr_wb = 1; llbit_wdata_wb = 0; tick(); clr_in();
    check("wb0_clear", llbit, 0);
    check("wb0_cnt", dut.pend_cnt_q, 0);
    wb_set(32'h2000); store_valid = 1; store_addr = 32'h2001; tick(); clr_in();
    check("snp_same_cycle", llbit, 0);
    // Relink moves the compare address
    wb_set(32'h2000); tick(); wb_set(32'h3000); tick(); clr_in();
    store_valid = 1; store_addr = 32'h2000; tick(); clr_in();
    check("relink_old_miss", llbit, 1);
    sc_issue = 1; sc_addr = 32'h3008; #1;
    check("sc_addr_miss", sc_success, 0);
    sc_addr = 32'h3002; #1;
    check("sc_addr_word_hit", sc_success, 1);
    sc_issue = 0;
    store_valid = 1; store_addr = 32'h3000; tick(); clr_in();
    check("relink_new_hit", llbit, 0);

    // Full / simultaneous counter
    repeat (4) begin ll_issue = 1; tick(); end
    clr_in();
    check("cnt_full_flag", pend_full, 1);
    check("cnt_full4", dut.pend_cnt_q, 4);
    ll_issue = 1; tick(); clr_in();
    check("cnt_no_wrap", dut.pend_cnt_q, 4);
    llbit_wr_wb = 1; tick(); clr_in();
    check("cnt_dec3", dut.pend_cnt_q, 3);
    check("cnt_not_full", pend_full, 0);
    ll_issue = 1; llbit_wr_wb = 1; tick(); clr_in();
    check("cnt_inc_dec", dut.pend_cnt_q, 3);
    repeat (3) begin llbit_wr_wb = 1; tick(); end
    clr_in();
    check("cnt_zero", dut.pend_cnt_q, 0);
    llbit_wr_wb = 1; tick(); clr_in();
    check("cnt_underflow", dut.pend_cnt_q, 0);

    // Flush
    repeat (3) begin ll_issue = 1; tick(); end
    clr_in();
    ll_issue = 1; wb_set(32'h5000); tick(); clr_in();
    check("fl_cnt3", dut.pend_cnt_q, 3);
    check("fl_linked", llbit, 1);
    sc_issue = 1; sc_addr = 32'h5000; #1;
    check("fl_stall_pre", stall_req, 1);
    excp_flush = 1; #1;
    check("fl_stall", stall_req, 0);
    check("fl_sc", sc_success, 0);
    tick(); clr_in();
    check("fl_cnt0", dut.pend_cnt_q, 0);
    check("fl_llbit", llbit, 0);

    // Async reset mid-operation
    wb_set(32'h6000); tick(); clr_in();
    repeat (2) begin ll_issue = 1; tick(); end
    clr_in();
    check("ar_cnt2", dut.pend_cnt_q, 2);
    sc_issue = 1; #2;
    check("ar_stall_pre", stall_req, 1);
    rst_n = 0; #1;
    check("ar_llbit", llbit, 0);
    check("ar_stall", stall_req, 0);
    check("ar_sc", sc_success, 0);
    check("ar_full", pend_full, 0);
    check("ar_cnt", dut.pend_cnt_q, 0);
    rst_n = 1; clr_in();
    ll_issue = 1; tick(); clr_in();
    check("ar_cnt_after", dut.pend_cnt_q, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
